wheel_sample_uc: RTL and testbench

WHEEL_SAMPLE_UC -- requirements
Module: wheel_sample_uc

---
 rtl/wheel_pkg.sv | 37 +++
 rtl/quad_decoder.sv | 49 ++++
 rtl/wheel_sample_uc.sv | 112 +++++++++++
 tb/tb_wheel_sample_uc.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/wheel_pkg.sv
// Shared types and constants for the wheel sampling controller: FSM state codes,
// quadrature step classification and the per-window pulse limit default.
package wheel_pkg;

   localparam int TIMER_W        = 20;
   localparam int CNT_W          = 3;
   localparam int MAX_PULSOS_DEF = 7;

   typedef enum logic [2:0] {
      INICIAL  = 3'd0,
      PREPARA  = 3'd1,
      AMOSTRA  = 3'd2,
      REGISTRA = 3'd3,
      ZERA     = 3'd4
   } estado_t;

   typedef enum logic [1:0] {
      PASSO_NENHUM,
      PASSO_CW,
      PASSO_CWW,
      PASSO_ILEGAL
   } passo_t;

   // Gray order 00->01->11->10->00 is CW; a two-bit jump has no defined direction.
   function automatic passo_t decodifica(input logic [1:0] ant, input logic [1:0] atual);
      passo_t p;
      p = PASSO_NENHUM;
      case ({ant, atual})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: p = PASSO_CW;
         4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: p = PASSO_CWW;
         4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: p = PASSO_ILEGAL;
         default:                                p = PASSO_NENHUM;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/quad_decoder.sv
// Quadrature front end: 2-flop synchronizer, previous-AB register and a registered
// step decode producing single-cycle CW / CWW / illegal indications.
module quad_decoder
   import wheel_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic enc_a,
   input  logic enc_b,
   output logic passo_cw,
   output logic passo_cww,
   output logic ilegal
);

   logic [1:0] sinc1_q, sinc2_q, ant_q, vld_q;
   logic       ant_vld_q, cw_q, cww_q, ilegal_q;
   passo_t     passo;

   assign passo = decodifica(ant_q, sinc2_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sinc1_q   <= '0;
         sinc2_q   <= '0;
         ant_q     <= '0;
         vld_q     <= '0;
         ant_vld_q <= 1'b0;
         cw_q      <= 1'b0;
         cww_q     <= 1'b0;
         ilegal_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples its pre-edge source.
         sinc1_q   <= {enc_a, enc_b};
         sinc2_q   <= sinc1_q;
         vld_q     <= {vld_q[0], 1'b1};
         ant_q     <= sinc2_q;
         // Decode stays off until the previous-AB register holds a real sample.
         ant_vld_q <= vld_q[1];
         cw_q      <= ant_vld_q && (passo == PASSO_CW);
         cww_q     <= ant_vld_q && (passo == PASSO_CWW);
         ilegal_q  <= ant_vld_q && (passo == PASSO_ILEGAL);
      end
   end

   assign passo_cw  = cw_q;
   assign passo_cww = cww_q;
   assign ilegal    = ilegal_q;

endmodule

// File: rtl/wheel_sample_uc.sv
// Wheel sampling control unit: windows the quadrature pulses, limits them per
// direction and sequences capture (registra) and clear (zera) of the wheel datapath.
module wheel_sample_uc
   import wheel_pkg::*;
#(
   parameter int JANELA     = 50000,
   parameter int MAX_PULSOS = MAX_PULSOS_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       parar,
   input  logic       enc_a,
   input  logic       enc_b,
   output logic       conta_CW,
   output logic       conta_CWW,
   output logic       registra,
   output logic       zera,
   output logic       pronto,
   output logic       saturou,
   output logic       erro_quad,
   output logic [2:0] db_estado
);

   localparam logic [TIMER_W-1:0] FIM    = TIMER_W'(JANELA - 1);
   localparam logic [CNT_W-1:0]   LIMITE = CNT_W'(MAX_PULSOS);

   estado_t            estado_q, estado_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0]   cnt_cw_q, cnt_cw_d, cnt_cww_q, cnt_cww_d;
   logic [CNT_W-1:0]   base_cw, base_cww;
   logic               conta_cw_q, conta_cw_d, conta_cww_q, conta_cww_d;
   logic               saturou_q, saturou_d, erro_q, erro_d;
   logic               passo_cw, passo_cww, ilegal, limpa, amostra_prox;

   quad_decoder u_quad (
      .clk       (clk),
      .reset     (reset),
      .enc_a     (enc_a),
      .enc_b     (enc_b),
      .passo_cw  (passo_cw),
      .passo_cww (passo_cww),
      .ilegal    (ilegal)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      estado_d     = estado_q;
      timer_d      = '0;
      limpa        = (estado_q == PREPARA) || (estado_q == ZERA);
      base_cw      = limpa ? '0 : cnt_cw_q;
      base_cww     = limpa ? '0 : cnt_cww_q;

      case (estado_q)
         INICIAL:  if (iniciar && !parar) estado_d = PREPARA;
         PREPARA:  estado_d = AMOSTRA;
         AMOSTRA:  if (timer_q == FIM) estado_d = REGISTRA;
         REGISTRA: estado_d = ZERA;
         ZERA:     estado_d = AMOSTRA;
         default:  estado_d = INICIAL;
      endcase
      if (parar) estado_d = INICIAL;

      if (estado_q == AMOSTRA && timer_q != FIM) timer_d = timer_q + 1'b1;

      // Gating on the next state keeps every emitted pulse inside an AMOSTRA cycle.
      amostra_prox = (estado_d == AMOSTRA);
      conta_cw_d   = passo_cw  && amostra_prox && (base_cw  < LIMITE);
      conta_cww_d  = passo_cww && amostra_prox && (base_cww < LIMITE);
      cnt_cw_d     = base_cw  + CNT_W'(conta_cw_d);
      cnt_cww_d    = base_cww + CNT_W'(conta_cww_d);

      saturou_d = saturou_q || (cnt_cw_d == LIMITE) || (cnt_cww_d == LIMITE);
      erro_d    = erro_q || ilegal;
      if (estado_q == PREPARA) begin
         saturou_d = 1'b0;
         erro_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q    <= INICIAL;
         timer_q     <= '0;
         cnt_cw_q    <= '0;
         cnt_cww_q   <= '0;
         conta_cw_q  <= 1'b0;
         conta_cww_q <= 1'b0;
         saturou_q   <= 1'b0;
         erro_q      <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         timer_q     <= timer_d;
         cnt_cw_q    <= cnt_cw_d;
         cnt_cww_q   <= cnt_cww_d;
         conta_cw_q  <= conta_cw_d;
         conta_cww_q <= conta_cww_d;
         saturou_q   <= saturou_d;
         erro_q      <= erro_d;
      end
   end

   assign conta_CW  = conta_cw_q;
   assign conta_CWW = conta_cww_q;
   assign registra  = (estado_q == REGISTRA);
   assign zera      = (estado_q == PREPARA) || (estado_q == ZERA);
   assign pronto    = (estado_q == ZERA);
   assign saturou   = saturou_q;
   assign erro_quad = erro_q;
   assign db_estado = estado_q;

endmodule

// File: tb/tb_wheel_sample_uc.sv
// Directed bench for wheel_sample_uc with JANELA=16: pulse expectations go into a
// scoreboard queue, a negedge monitor matches them; state and flags are checked inline.
module tb_wheel_sample_uc;

   logic       clk = 1'b0;
   logic       reset, iniciar, parar, enc_a, enc_b;
   logic       conta_CW, conta_CWW, registra, zera, pronto, saturou, erro_quad;
   logic [2:0] db_estado;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   typedef struct {
      logic ccw;
      int   cyc;
   } evt_t;

   evt_t exp_q[$];

   wheel_sample_uc #(.JANELA(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .iniciar   (iniciar),
      .parar     (parar),
      .enc_a     (enc_a),
      .enc_b     (enc_b),
      .conta_CW  (conta_CW),
      .conta_CWW (conta_CWW),
      .registra  (registra),
      .zera      (zera),
      .pronto    (pronto),
      .saturou   (saturou),
      .erro_quad (erro_quad),
      .db_estado (db_estado)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Drive a new AB pair; kind -1 = no pulse expected, 0 = CW, 1 = CWW.
   task automatic mover(input logic [1:0] ab, input int kind);
      evt_t e;
      {enc_a, enc_b} = ab;
      if (kind >= 0) begin
         e.ccw = (kind == 1);
         e.cyc = cyc + 4;
         exp_q.push_back(e);
      end
   endtask

   // Scoreboard monitor: every conta pulse must match the head of the queue.
   always @(negedge clk) begin
      evt_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         checks++;
         fails++;
         $display("FAIL missed_pulse: expected %s at cycle %0d, got no pulse", e.ccw ? "CWW" : "CW", e.cyc);
      end
      if (conta_CW && conta_CWW) begin
         checks++;
         fails++;
         $display("FAIL both_dirs at cycle %0d: got CW=1 CWW=1 expected at most one", cyc);
      end else if (conta_CW || conta_CWW) begin
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse at cycle %0d: got CW=%0b CWW=%0b expected none", cyc, conta_CW, conta_CWW);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.ccw != conta_CWW) begin
               fails++;
               $display("FAIL pulse_match: got CWW=%0b at cycle %0d expected CWW=%0b at cycle %0d",
                        conta_CWW, cyc, e.ccw, e.cyc);
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [1:0] seq_cww [4];
      seq_cww = '{2'b11, 2'b01, 2'b00, 2'b10};
      reset   = 1'b1;
      iniciar = 1'b0;
      parar   = 1'b0;
      {enc_a, enc_b} = 2'b00;

      wait_cyc(2);
      check("reset_outputs", {25'd0, conta_CW, conta_CWW, registra, zera, pronto, saturou, erro_quad}, 32'd0);
      check("reset_estado", db_estado, 0);
      wait_cyc(3);
      reset = 1'b0;

      // Start: PREPARA for one cycle with zera, AMOSTRA entered at edge 10.
      wait_cyc(8);
      iniciar = 1'b1;
      wait_cyc(9);
      iniciar = 1'b0;
      check("prepara_estado", db_estado, 1);
      check("prepara_zera", zera, 1);
      wait_cyc(10);
      check("amostra_estado", db_estado, 2);
      check("amostra_zera", zera, 0);

      // Window 0: three CW steps two cycles apart.
      wait_cyc(11); mover(2'b01, 0);
      wait_cyc(13); mover(2'b11, 0);
      wait_cyc(15); mover(2'b10, 0);

      wait_cyc(25);
      check("registra_early", registra, 0);
      wait_cyc(26);
      check("registra_estado", db_estado, 3);
      check("registra_pulse", registra, 1);
      wait_cyc(27);
      check("zera_estado", db_estado, 4);
      check("pronto_pulse", {30'd0, pronto, zera}, 32'd3);

      // Window 1: ten CWW steps, only seven may pass.
      for (int i = 0; i < 10; i++) begin
         wait_cyc(28 + i);
         mover(seq_cww[i % 4], (i < 7) ? 1 : -1);
         if (i == 2) check("saturou_before", saturou, 0);
      end
      wait_cyc(40);
      check("saturou_set", saturou, 1);
      wait_cyc(44);
      check("period_registra", db_estado, 3);
      wait_cyc(45);
      check("period_pronto", pronto, 1);

      // Window 2: counting resumes, flag stays sticky.
      wait_cyc(50); mover(2'b00, 1);
      wait_cyc(56);
      check("saturou_sticky", saturou, 1);
      check("erro_before", erro_quad, 0);
      wait_cyc(58); mover(2'b11, -1);
      wait_cyc(66);
      check("erro_quad_set", erro_quad, 1);

      // Window 3: parar arrives together with timer=15.
      wait_cyc(79);
      check("before_parar", db_estado, 2);
      parar = 1'b1;
      wait_cyc(80);
      parar = 1'b0;
      check("parar_estado", db_estado, 0);
      check("parar_no_registra", registra, 0);
      wait_cyc(81);
      check("parar_hold", {29'd0, registra, saturou, erro_quad}, 32'd3);

      // Restart clears both sticky flags.
      wait_cyc(83);
      iniciar = 1'b1;
      wait_cyc(84);
      iniciar = 1'b0;
      check("restart_prepara", db_estado, 1);
      wait_cyc(85);
      check("restart_flags", {30'd0, saturou, erro_quad}, 32'd0);
      check("restart_amostra", db_estado, 2);

      // Reset lands in the middle of a CW pulse.
      wait_cyc(87); mover(2'b10, 0);
      wait_cyc(91);
      #2;
      check("pulse_before_reset", conta_CW, 1);
      reset = 1'b1;
      #1;
      check("reset_async_conta", conta_CW, 0);
      check("reset_async_estado", db_estado, 0);
      check("reset_no_registra", registra, 0);
      {enc_a, enc_b} = 2'b11;
      wait_cyc(95);
      reset = 1'b0;

      // Pins already at 11 after reset: no spurious step or error; INICIAL drops steps.
      wait_cyc(100); mover(2'b10, -1);
      wait_cyc(106);
      check("post_reset_erro", erro_quad, 0);
      check("post_reset_estado", db_estado, 0);

      wait_cyc(110);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
